bcd2bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter for score/length entry in the snake game.

---
 rtl/bcd2bin_seq_if.sv | 35 +++
 rtl/bcd2bin_seq.sv | 128 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// ----------------------------------------------------------------------------
// bcd2bin_seq_if
//   Request/response bundle for the sequential BCD-to-binary converter.
//   master: issues START with the three BCD digits, receives BUSY/DONE/ERR/B.
//   slave : the converter side.
// Signals
//   start     request strobe, only honoured while the converter is idle
//   hundreds  BCD hundreds digit (0-3)
//   tens      BCD tens digit
//   ones      BCD ones digit
//   busy      high while the conversion is shifting
//   done      one-cycle pulse, b/err valid from this cycle
//   err       last request was invalid (digit > 9 or value > 255)
//   b         8-bit binary result, held until the next done
// ----------------------------------------------------------------------------
interface bcd2bin_seq_if;
   logic       start;
   logic [1:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] b;

   modport master (
      output start, hundreds, tens, ones,
      input  busy, done, err, b
   );

   modport slave (
      input  start, hundreds, tens, ones,
      output busy, done, err, b
   );
endinterface

// File: rtl/bcd2bin_seq.sv
// ----------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble,
//   one right shift per clock). Used for score/length entry; the inverse of
//   the score display path.
// Parameters
//   SAT_ON_OVF  1: b = 8'hFF on an invalid request, 0: b = 8'h00
// Ports
//   clk_i   system clock, rising edge
//   rst_i   asynchronous, active-high reset
//   bus     bcd2bin_seq_if.slave: start/digits in, busy/done/err/b out
// Timing
//   valid request   : busy for 8 cycles, done one cycle later (t0+9)
//   invalid request : no shifting, done at t0+1 with err set
// ----------------------------------------------------------------------------
module bcd2bin_seq #(
   parameter bit SAT_ON_OVF = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   bcd2bin_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [7:0] ERR_VALUE = SAT_ON_OVF ? 8'hFF : 8'h00;

   state_t      state_q;
   logic [17:0] work_q;   // {hundreds[1:0], tens[3:0], ones[3:0], binary[7:0]}
   logic [2:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [7:0]  b_q;

   logic [17:0] shifted_d;
   logic [17:0] work_d;
   logic [3:0]  tens_d;
   logic [3:0]  ones_d;
   logic [9:0]  value_d;
   logic        valid_d;

   // One reverse double-dabble step: shift first, then correct the shifted
   // digits. The 2-bit hundreds field, zero-extended, can never reach 8, so
   // it needs no correction term.
   always_comb begin
      // NOTE: every variable gets a value before any conditional update, so
      // no path leaves it unassigned and no latch is inferred.
      shifted_d = work_q >> 1;
      tens_d    = shifted_d[15:12];
      ones_d    = shifted_d[11:8];
      if (tens_d >= 4'd8) tens_d = tens_d - 4'd3;
      if (ones_d >= 4'd8) ones_d = ones_d - 4'd3;
      work_d = {shifted_d[17:16], tens_d, ones_d, shifted_d[7:0]};
   end

   // Range check on the raw inputs; an out-of-range value (e.g. 256..399)
   // is rejected even though each digit on its own is legal.
   assign value_d = 10'(bus.hundreds) * 10'd100
                  + 10'(bus.tens)     * 10'd10
                  + 10'(bus.ones);
   assign valid_d = (bus.tens <= 4'd9) && (bus.ones <= 4'd9) && (value_d <= 10'd255);

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         b_q     <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  if (valid_d) begin
                     work_q  <= {bus.hundreds, bus.tens, bus.ones, 8'h00};
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= CONV;
                  end else begin
                     // Invalid request skips the shifter entirely.
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     b_q     <= ERR_VALUE;
                     state_q <= FIN;
                  end
               end
            end
            CONV: begin
               work_q <= work_d;
               cnt_q  <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  // Eighth shift: the low byte of the corrected value is final.
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
                  b_q     <= work_d[7:0];
                  state_q <= FIN;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
   assign bus.b    = b_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd2bin_seq
//   Self-checking bench for bcd2bin_seq. Two instances share the stimulus,
//   one with SAT_ON_OVF=1 and one with SAT_ON_OVF=0. Expected results come
//   from a plain arithmetic model of the conversion rules.
// ----------------------------------------------------------------------------
module tb_bcd2bin_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bcd2bin_seq_if sat_if ();
   bcd2bin_seq_if zero_if ();

   bcd2bin_seq #(.SAT_ON_OVF(1'b1)) dut_sat (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sat_if.slave)
   );

   bcd2bin_seq #(.SAT_ON_OVF(1'b0)) dut_zero (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (zero_if.slave)
   );

   // Reference: {err, b} from the decimal value of the digits.
   function automatic logic [8:0] model(input int h, input int t, input int o, input bit sat);
      int v;
      v = 100 * h + 10 * t + o;
      if (t > 9 || o > 9 || v > 255) return {1'b1, (sat ? 8'hFF : 8'h00)};
      return {1'b0, v[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                        input logic st);
      sat_if.start     = st;
      sat_if.hundreds  = h;
      sat_if.tens      = t;
      sat_if.ones      = o;
      zero_if.start    = st;
      zero_if.hundreds = h;
      zero_if.tens     = t;
      zero_if.ones     = o;
   endtask

   // One request issued from idle; checks latency, busy length, results and
   // that done is a single-cycle pulse with b held afterwards.
   task automatic do_req(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                         input string tag);
      logic [8:0] exp_s;
      logic [8:0] exp_z;
      int         done_at;
      int         busy_cnt;
      bit         overlap;
      exp_s = model(int'(h), int'(t), int'(o), 1'b1);
      exp_z = model(int'(h), int'(t), int'(o), 1'b0);
      drive(h, t, o, 1'b1);
      @(posedge clk);
      #1 drive(2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      done_at  = 0;
      busy_cnt = 0;
      overlap  = 1'b0;
      for (int k = 1; k <= 20 && done_at == 0; k++) begin
         @(negedge clk);
         if (sat_if.busy) busy_cnt++;
         if (sat_if.busy && sat_if.done) overlap = 1'b1;
         if (sat_if.done) done_at = k;
      end
      check({tag, " done_at"}, done_at, (exp_s[8] ? 1 : 9));
      check({tag, " busy_cycles"}, busy_cnt, (exp_s[8] ? 0 : 8));
      check({tag, " busy_done_overlap"}, overlap, 0);
      check({tag, " err_sat"}, sat_if.err, exp_s[8]);
      check({tag, " b_sat"}, sat_if.b, exp_s[7:0]);
      check({tag, " err_zero"}, zero_if.err, exp_z[8]);
      check({tag, " b_zero"}, zero_if.b, exp_z[7:0]);
      @(negedge clk);
      check({tag, " done_pulse"}, sat_if.done, 0);
      check({tag, " b_held"}, sat_if.b, exp_s[7:0]);
   endtask

   initial begin
      int         q[$];
      int         cnt;
      int         off;
      int         n;
      bit         seen;

      // Reset state
      drive(2'd0, 4'd0, 4'd0, 1'b0);
      #12;
      check("rst busy", sat_if.busy, 0);
      check("rst done", sat_if.done, 0);
      check("rst err", sat_if.err, 0);
      check("rst b", sat_if.b, 0);
      @(negedge clk);
      rst = 1'b0;

      // Top of range and invalid requests
      do_req(2'd2, 4'd5, 4'd5, "max255");
      do_req(2'd2, 4'd5, 4'd6, "ovf256");
      do_req(2'd0, 4'd0, 4'hA, "ones_A");

      // Asynchronous reset between edges clears outputs at once
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst err", sat_if.err, 0);
      check("async rst b", sat_if.b, 0);
      check("async rst busy", sat_if.busy, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed values and range edges
      do_req(2'd1, 4'd2, 4'd8, "v128");
      do_req(2'd0, 4'd0, 4'd0, "v0");
      do_req(2'd0, 4'd9, 4'd9, "v99");
      do_req(2'd1, 4'd9, 4'd9, "v199");
      do_req(2'd2, 4'd5, 4'd9, "v259");
      do_req(2'd2, 4'd6, 4'd0, "v260");
      do_req(2'd3, 4'd0, 4'd0, "v300");
      do_req(2'd0, 4'hF, 4'd0, "tens_F");

      // Every legal value, starting at a random offset
      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
         n = (i + off) % 256;
         do_req(2'(n / 100), 4'((n / 10) % 10), 4'(n % 10), $sformatf("all%0d", n));
      end

      // Random digits, legal or not
      for (int i = 0; i < 40; i++) begin
         do_req(2'($urandom), 4'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
      end

      // START re-pulsed at t0+3 with other digits is ignored
      drive(2'd1, 4'd2, 4'd8, 1'b1);
      @(posedge clk);
      #1 drive(2'd0, 4'd0, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      drive(2'd0, 4'd4, 4'd2, 1'b1);
      @(posedge clk);
      #1 drive(2'd0, 4'd0, 4'd0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (sat_if.done) seen = 1'b1;
      end
      check("repulse done", seen, 1);
      check("repulse b", sat_if.b, 8'd128);
      check("repulse err", sat_if.err, 0);
      @(negedge clk);
      check("repulse no second done", sat_if.done, 0);

      // START held high: dones exactly 10 cycles apart
      drive(2'd1, 4'd7, 4'd3, 1'b1);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (sat_if.done) q.push_back(k);
      end
      drive(2'd0, 4'd0, 4'd0, 1'b0);
      check("held done count", (q.size() >= 3), 1);
      if (q.size() >= 3) begin
         check("held spacing 1", q[1] - q[0], 10);
         check("held spacing 2", q[2] - q[1], 10);
      end
      check("held b", sat_if.b, 8'd173);
      repeat (12) @(negedge clk);

      // Reset at t0+4 aborts without a done
      drive(2'd1, 4'd0, 4'd0, 1'b1);
      @(posedge clk);
      #1 drive(2'd0, 4'd0, 4'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort b", sat_if.b, 0);
      check("abort busy", sat_if.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (sat_if.done) cnt++;
      end
      check("abort no done", cnt, 0);
      check("abort b after", sat_if.b, 0);
      check("abort err after", sat_if.err, 0);
      do_req(2'd2, 4'd0, 4'd0, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
